// File: rtl/miriscv_timer_pkg.sv
// Shared definitions for the miriscv_timer block: register offsets, CTRL layout
// and the byte-enable merge used by every writable register.
package miriscv_timer_pkg;

   // Word offsets as decoded from addr_i[4:2]
   localparam logic [2:0] TMR_CTRL   = 3'd0;
   localparam logic [2:0] TMR_LOAD   = 3'd1;
   localparam logic [2:0] TMR_COUNT  = 3'd2;
   localparam logic [2:0] TMR_STATUS = 3'd3;
   localparam logic [2:0] TMR_PRESC  = 3'd4;

   localparam int unsigned CTRL_EN          = 0;
   localparam int unsigned CTRL_AUTO_RELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN      = 2;

   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } ctrl_t;

   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the timer enable into one tick every presc_i+1 enabled cycles.
module timer_prescaler #(
   parameter int unsigned PRESC_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_i,
   input  logic                   clr_i,
   input  logic [PRESC_WIDTH-1:0] presc_i,
   output logic                   tick_o
);

   logic [PRESC_WIDTH-1:0] cnt_q;
   logic                   at_limit;

   assign at_limit = (cnt_q == presc_i);
   // A divider being reprogrammed must not emit a tick based on its old phase.
   assign tick_o   = en_i & ~clr_i & at_limit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i || !en_i) begin
         cnt_q <= '0;
      end else if (at_limit) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PRESC_WIDTH'(1);
      end
   end

endmodule

// File: rtl/miriscv_timer.sv
// Memory-mapped compare/reload timer with interrupt handshake toward the interrupt controller.
// Define MIRISCV_TIMER_PRESC_EN to add the PRESC register (offset 0x10) and prescaler.
module miriscv_timer
   import miriscv_timer_pkg::*;
#(
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned PRESC_WIDTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        int_req_o,
   input  logic        int_fin_i
);

   ctrl_t                ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0] load_q, load_d, count_q, count_d;
   logic                 pending_q, pending_d;
   logic [31:0]          rdata_d, load_merged, count_merged, presc_rd;
   logic [2:0]           reg_sel;
   logic                 wr_en, rd_en, wr_ctrl, wr_load, wr_count, wr_status;
   logic                 tick, tick_eff, match, clr_pending;
   logic                 unused_bits;

   assign reg_sel   = addr_i[4:2];
   assign wr_en     = req_i & we_i;
   assign rd_en     = req_i & ~we_i;
   assign wr_ctrl   = wr_en & (reg_sel == TMR_CTRL);
   assign wr_load   = wr_en & (reg_sel == TMR_LOAD);
   assign wr_count  = wr_en & (reg_sel == TMR_COUNT);
   assign wr_status = wr_en & (reg_sel == TMR_STATUS);

   assign load_merged  = be_merge(32'(load_q), wdata_i, be_i);
   assign count_merged = be_merge(32'(count_q), wdata_i, be_i);

`ifdef MIRISCV_TIMER_PRESC_EN
   logic [PRESC_WIDTH-1:0] presc_q;
   logic [31:0]            presc_merged;
   logic                   wr_presc;

   assign wr_presc     = wr_en & (reg_sel == TMR_PRESC);
   assign presc_merged = be_merge(32'(presc_q), wdata_i, be_i);
   assign presc_rd     = 32'(presc_q);

   always_ff @(posedge clk_i) begin
      if (rst_i)         presc_q <= '0;
      else if (wr_presc) presc_q <= presc_merged[PRESC_WIDTH-1:0];
   end

   timer_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_prescaler (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (ctrl_q.en),
      .clr_i   (wr_presc),
      .presc_i (presc_q),
      .tick_o  (tick)
   );

   assign unused_bits = ^{addr_i[31:5], addr_i[1:0], load_merged, count_merged, presc_merged};
`else
   logic [PRESC_WIDTH-1:0] unused_presc;

   assign tick         = ctrl_q.en;
   assign presc_rd     = '0;
   assign unused_presc = '0;
   assign unused_bits  = ^{addr_i[31:5], addr_i[1:0], load_merged, count_merged};
`endif

   // A bus write to CTRL or COUNT owns this cycle; the tick is dropped entirely.
   assign tick_eff    = tick & ~wr_ctrl & ~wr_count;
   assign match       = (count_q == load_q);
   assign clr_pending = int_fin_i | (wr_status & be_i[0] & wdata_i[0]);

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      count_d   = count_q;
      if (tick_eff) begin
         if (!match)                   count_d   = count_q + CNT_WIDTH'(1);
         else if (ctrl_q.auto_reload)  count_d   = '0;
         else                          ctrl_d.en = 1'b0;
      end
      if (wr_ctrl && be_i[0]) begin
         ctrl_d.en          = wdata_i[CTRL_EN];
         ctrl_d.auto_reload = wdata_i[CTRL_AUTO_RELOAD];
         ctrl_d.irq_en      = wdata_i[CTRL_IRQ_EN];
      end
      if (wr_load)  load_d  = load_merged[CNT_WIDTH-1:0];
      if (wr_count) count_d = count_merged[CNT_WIDTH-1:0];
      // Set beats clear so a match coinciding with acknowledge is never lost.
      pending_d = (tick_eff & match) | (pending_q & ~clr_pending);
   end

   always_comb begin
      rdata_d = '0;
      case (reg_sel)
         TMR_CTRL:   rdata_d = 32'(ctrl_q);
         TMR_LOAD:   rdata_d = 32'(load_q);
         TMR_COUNT:  rdata_d = 32'(count_q);
         TMR_STATUS: rdata_d = {31'b0, pending_q};
         TMR_PRESC:  rdata_d = presc_rd;
         default:    rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q    <= '0;
         load_q    <= '1;
         count_q   <= '0;
         pending_q <= 1'b0;
         rdata_o   <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         if (rd_en) rdata_o <= rdata_d;
      end
   end

   assign int_req_o = pending_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_miriscv_timer.sv
// Self-checking bench for miriscv_timer: register table plus cycle-exact timer sequences.
module tb_miriscv_timer;

   localparam logic [31:0] A_CTRL   = 32'h00;
   localparam logic [31:0] A_LOAD   = 32'h04;
   localparam logic [31:0] A_COUNT  = 32'h08;
   localparam logic [31:0] A_STATUS = 32'h0C;
   localparam logic [31:0] A_PRESC  = 32'h10;

   logic        clk_i = 1'b0;
   logic        rst_i, req_i, we_i, int_fin_i, int_req_o;
   logic [3:0]  be_i;
   logic [31:0] addr_i, wdata_i, rdata_o;

   always #5 clk_i = ~clk_i;

   miriscv_timer dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .we_i      (we_i),
      .be_i      (be_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .rdata_o   (rdata_o),
      .int_req_o (int_req_o),
      .int_fin_i (int_fin_i)
   );

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp;
      string       name;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Read responses are matched against the scoreboard one edge after the request.
   always @(posedge clk_i) begin
      if (req_i && !we_i) begin
         #1;
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: read data 0x%08h with no expectation queued", rdata_o);
         end else begin
            sb_t item;
            item = sb_q.pop_front();
            check(item.name, rdata_o, item.exp);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
      req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
      step(1);
      req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name,
                     input logic [3:0] be = 4'h0);
      sb_t item;
      item.exp  = exp;
      item.name = name;
      sb_q.push_back(item);
      req_i = 1'b1; we_i = 1'b0; addr_i = a; be_i = be;
      step(1);
      req_i = 1'b0;
   endtask

   task automatic chk_irq(input string name, input logic exp);
      check(name, {31'b0, int_req_o}, {31'b0, exp});
   endtask

   task automatic pulse_fin();
      int_fin_i = 1'b1;
      step(1);
      int_fin_i = 1'b0;
   endtask

   task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp, input string name);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = d; v.be = be; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
      addr_i = '0; wdata_i = '0; int_fin_i = 1'b0;

      add(0, A_CTRL,   32'h0,         4'h0, 32'h0000_0000, "rst_ctrl");
      add(0, A_LOAD,   32'h0,         4'h0, 32'hFFFF_FFFF, "rst_load");
      add(0, A_COUNT,  32'h0,         4'h0, 32'h0000_0000, "rst_count");
      add(0, A_STATUS, 32'h0,         4'h0, 32'h0000_0000, "rst_status");
      add(0, A_PRESC,  32'h0,         4'h0, 32'h0000_0000, "rst_presc");
      add(0, 32'h14,   32'h0,         4'h0, 32'h0000_0000, "unmapped_rd");
      add(1, A_LOAD,   32'hAABB_CCDD, 4'h2, 32'h0,         "");
      add(0, A_LOAD,   32'h0,         4'h0, 32'hFFFF_CCFF, "byte_wr_load");
      add(1, A_LOAD,   32'h1234_5678, 4'hF, 32'h0,         "");
      add(0, A_LOAD,   32'h0,         4'h0, 32'h1234_5678, "full_wr_load");
      add(1, A_LOAD,   32'hFFFF_FFFF, 4'h0, 32'h0,         "");
      add(0, A_LOAD,   32'h0,         4'h0, 32'h1234_5678, "be0_ignored");
      add(1, A_COUNT,  32'hAB00_0055, 4'h1, 32'h0,         "");
      add(0, A_COUNT,  32'h0,         4'h0, 32'h0000_0055, "count_byte0");
      add(1, A_CTRL,   32'hFFFF_FFF2, 4'hF, 32'h0,         "");
      add(0, A_CTRL,   32'h0,         4'h0, 32'h0000_0002, "ctrl_high_zero");
      add(1, A_CTRL,   32'h0,         4'hF, 32'h0,         "");
      add(1, 32'h14,   32'hFFFF_FFFF, 4'hF, 32'h0,         "");
      add(0, 32'h1C,   32'h0,         4'h0, 32'h0000_0000, "unmapped_rd2");
      add(1, A_STATUS, 32'h1,         4'hF, 32'h0,         "");
      add(0, A_STATUS, 32'h0,         4'h0, 32'h0000_0000, "w1c_idle");
      add(0, A_COUNT,  32'h0,         4'hF, 32'h0000_0055, "count_frozen");
      add(0, A_LOAD,   32'h0,         4'hF, 32'h1234_5678, "load_final");

      step(2);
      rst_i = 1'b0;
      chk_irq("rst_irq", 1'b0);
      check("rst_rdata", rdata_o, 32'h0);

      foreach (vecs[i]) begin
         if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
         else            rd(vecs[i].addr, vecs[i].exp, vecs[i].name, vecs[i].be);
      end

      // Read latency and hold: new data only after the edge, then held while idle.
      begin
         sb_t item;
         item.exp = 32'h55; item.name = "lat_count";
         sb_q.push_back(item);
         req_i = 1'b1; we_i = 1'b0; addr_i = A_COUNT;
         #1 check("lat_not_comb", rdata_o, 32'h1234_5678);
         @(posedge clk_i); #1;
         req_i = 1'b0;
      end
      wr(A_LOAD, 32'h0000_0004);
      step(2);
      check("rdata_hold", rdata_o, 32'h55);

      // Periodic: LOAD=4, enable with IRQ and auto-reload.
      wr(A_COUNT, 32'h0);
      wr(A_CTRL, 32'h7);
      for (int i = 0; i < 5; i++) begin
         chk_irq("per_low", 1'b0);
         step(1);
      end
      chk_irq("per_rise", 1'b1);
      pulse_fin();
      chk_irq("per_fin_drop", 1'b0);
      step(3);
      chk_irq("per_before_repeat", 1'b0);
      step(1);
      chk_irq("per_repeat", 1'b1);
      wr(A_STATUS, 32'h1);
      chk_irq("per_w1c_drop", 1'b0);
      wr(A_CTRL, 32'h0);
      rd(A_COUNT, 32'h1, "ctrl_wr_collision");

      // IRQ_EN masks the request while PENDING still sets.
      wr(A_COUNT, 32'h0);
      wr(A_CTRL, 32'h3);
      for (int i = 0; i < 6; i++) begin
         chk_irq("mask_low", 1'b0);
         step(1);
      end
      rd(A_STATUS, 32'h1, "mask_pending");
      wr(A_CTRL, 32'h7);
      chk_irq("unmask", 1'b1);
      wr(A_CTRL, 32'h0);
      pulse_fin();
      rd(A_STATUS, 32'h0, "fin_clear");
      pulse_fin();
      rd(A_STATUS, 32'h0, "fin_idle");

      // One-shot: LOAD=3, CTRL=EN|IRQ_EN.
      wr(A_LOAD, 32'h3);
      wr(A_COUNT, 32'h0);
      wr(A_CTRL, 32'h5);
      for (int i = 0; i < 4; i++) begin
         chk_irq("os_low", 1'b0);
         step(1);
      end
      chk_irq("os_rise", 1'b1);
      rd(A_COUNT, 32'h3, "os_count");
      rd(A_CTRL, 32'h4, "os_ctrl");
      pulse_fin();
      step(10);
      chk_irq("os_no_second", 1'b0);
      rd(A_COUNT, 32'h3, "os_count_held");

      // Match and STATUS W1C in the same cycle: set wins.
      wr(A_LOAD, 32'h2);
      wr(A_COUNT, 32'h0);
      wr(A_CTRL, 32'h7);
      step(2);
      wr(A_STATUS, 32'h1);
      chk_irq("w1c_collision", 1'b1);
      wr(A_CTRL, 32'h0);
      wr(A_STATUS, 32'h1, 4'hE);
      rd(A_STATUS, 32'h1, "w1c_be_masked");
      wr(A_STATUS, 32'h1, 4'h1);
      rd(A_STATUS, 32'h0, "w1c_clear");

      // COUNT write in a tick cycle keeps the written value.
      wr(A_LOAD, 32'h100);
      wr(A_COUNT, 32'h0);
      wr(A_CTRL, 32'h1);
      wr(A_COUNT, 32'h40);
      rd(A_COUNT, 32'h40, "count_wr_collision");
      wr(A_CTRL, 32'h0);
      rd(A_COUNT, 32'h41, "count_after_tick");

      // LOAD below COUNT matches only after wrapping through zero.
      wr(A_LOAD, 32'h2);
      wr(A_COUNT, 32'hFFFF_FFFE);
      wr(A_CTRL, 32'h5);
      for (int i = 0; i < 5; i++) begin
         chk_irq("wrap_low", 1'b0);
         step(1);
      end
      chk_irq("wrap_rise", 1'b1);
      rd(A_COUNT, 32'h2, "wrap_count");
      pulse_fin();

      // LOAD=0 with auto-reload matches every tick; fin in a match cycle is overridden.
      wr(A_LOAD, 32'h0);
      wr(A_COUNT, 32'h0);
      wr(A_CTRL, 32'h3);
      step(1);
      pulse_fin();
      rd(A_STATUS, 32'h1, "fin_match_collision");
      wr(A_CTRL, 32'h0);
      rd(A_COUNT, 32'h0, "load0_count");
      pulse_fin();

      // Reset for two cycles just before a match.
      wr(A_LOAD, 32'h1);
      wr(A_COUNT, 32'h0);
      wr(A_CTRL, 32'h7);
      rd(A_LOAD, 32'h1, "pre_reset_load");
      rst_i = 1'b1;
      chk_irq("rst_irq_c0", 1'b0);
      step(1);
      chk_irq("rst_irq_c1", 1'b0);
      step(1);
      rst_i = 1'b0;
      chk_irq("rst_irq_c2", 1'b0);
      check("rst_mid_rdata", rdata_o, 32'h0);
      rd(A_CTRL,   32'h0000_0000, "rst_mid_ctrl");
      rd(A_LOAD,   32'hFFFF_FFFF, "rst_mid_load");
      rd(A_COUNT,  32'h0000_0000, "rst_mid_count");
      rd(A_STATUS, 32'h0000_0000, "rst_mid_status");
      chk_irq("rst_irq_after", 1'b0);

`ifdef MIRISCV_TIMER_PRESC_EN
      wr(A_PRESC, 32'h2);
      wr(A_LOAD, 32'h1);
      wr(A_COUNT, 32'h0);
      wr(A_CTRL, 32'h7);
      for (int i = 0; i < 6; i++) begin
         chk_irq("presc_low", 1'b0);
         step(1);
      end
      chk_irq("presc_rise", 1'b1);
      rd(A_PRESC, 32'h2, "presc_readback");
      wr(A_CTRL, 32'h0);
      pulse_fin();
`else
      wr(A_PRESC, 32'hFFFF_FFFF);
      rd(A_PRESC, 32'h0, "presc_absent");
`endif

      step(2);
      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
